// File: rtl/reg_file_fwd.sv
// Architectural register file with per-port forward-select generation and a dedicated R0 write path.
// Optional: define REG_FILE_RST_CLEAR_EN to clear the array on rst; otherwise the array has no reset.
module reg_file_fwd #(
    parameter int REG_DATA_WIDTH    = 16,
    parameter int REG_NUM_WIDTH     = 4,
    parameter int REG_FORWARD_WIDTH = 2,
    parameter int NUM_REGISTERS     = 16,
    parameter logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_REG_FILE = 2'b00,
    parameter logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_WB       = 2'b01,
    parameter logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_R0       = 2'b10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REG_NUM_WIDTH-1:0]     ra_num,
    input  logic [REG_NUM_WIDTH-1:0]     rb_num,
    input  logic                         wr_en,
    input  logic [REG_NUM_WIDTH-1:0]     wr_num,
    input  logic [REG_DATA_WIDTH-1:0]    wr_data,
    input  logic                         r0_wr_en,
    input  logic [REG_DATA_WIDTH-1:0]    r0_wr_data,
    output logic [REG_DATA_WIDTH-1:0]    ra_data,
    output logic [REG_DATA_WIDTH-1:0]    rb_data,
    output logic [REG_FORWARD_WIDTH-1:0] ra_forward,
    output logic [REG_FORWARD_WIDTH-1:0] rb_forward,
    output logic [REG_DATA_WIDTH-1:0]    wrd,
    output logic [REG_DATA_WIDTH-1:0]    r0d,
    output logic                         wr_exception
);

    // One extra bit so NUM_REGISTERS == 2**REG_NUM_WIDTH is representable.
    localparam logic [REG_NUM_WIDTH:0] NUM_REGS_W = (REG_NUM_WIDTH+1)'(NUM_REGISTERS);

    logic [REG_DATA_WIDTH-1:0] regs [NUM_REGISTERS];

    logic wr_in_range;
    logic ra_in_range;
    logic rb_in_range;

    assign wr_in_range = ({1'b0, wr_num} < NUM_REGS_W);
    assign ra_in_range = ({1'b0, ra_num} < NUM_REGS_W);
    assign rb_in_range = ({1'b0, rb_num} < NUM_REGS_W);

    function automatic logic [REG_FORWARD_WIDTH-1:0] fwd_sel(
        input logic                     in_reset,
        input logic                     r0_en,
        input logic                     wb_en,
        input logic                     wb_ok,
        input logic [REG_NUM_WIDTH-1:0] wb_num,
        input logic [REG_NUM_WIDTH-1:0] rd_num
    );
        logic [REG_FORWARD_WIDTH-1:0] sel;
        sel = REG_FORWARD_REG_FILE;
        if (!in_reset) begin
            if (r0_en && (rd_num == '0))
                sel = REG_FORWARD_R0;
            else if (wb_en && wb_ok && (wb_num == rd_num))
                sel = REG_FORWARD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        ra_forward = fwd_sel(rst, r0_wr_en, wr_en, wr_in_range, wr_num, ra_num);
        rb_forward = fwd_sel(rst, r0_wr_en, wr_en, wr_in_range, wr_num, rb_num);
    end

    assign ra_data = ra_in_range ? regs[ra_num] : '0;
    assign rb_data = rb_in_range ? regs[rb_num] : '0;
    assign wrd     = wr_data;
    assign r0d     = r0_wr_data;

    // The R0 port assignment comes last so it overrides a same-cycle writeback to R0.
`ifdef REG_FILE_RST_CLEAR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGISTERS; i++)
                regs[i] <= '0;
        end else begin
            if (wr_en && wr_in_range)
                regs[wr_num] <= wr_data;
            if (r0_wr_en)
                regs[0] <= r0_wr_data;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr_en && wr_in_range)
                regs[wr_num] <= wr_data;
            if (r0_wr_en)
                regs[0] <= r0_wr_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            wr_exception <= 1'b0;
        else if (wr_en && !wr_in_range)
            wr_exception <= 1'b1;
    end

endmodule
